// File: rtl/ctrl_pkg.sv
// Shared state encoding, instruction class codes and writeback-select constants
// for the multi-cycle control sequencer.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [2:0] CLS_LOAD  = 3'b000;
    localparam logic [2:0] CLS_STORE = 3'b001;
    localparam logic [2:0] CLS_ARITH = 3'b010;
    localparam logic [2:0] CLS_IMM   = 3'b011;
    localparam logic [2:0] CLS_JMP   = 3'b100;
    localparam logic [2:0] CLS_JCOND = 3'b101;

    localparam logic WB_ALU = 1'b0;
    localparam logic WB_MEM = 1'b1;

endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive request cycles without ack; timeout_o is combinational and fires in
// the TIMEOUT-th unanswered cycle. An ack in that same cycle suppresses the timeout.
module mem_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic ack_i,
    input  logic clr_i,
    output logic timeout_o
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout_o = req_i && !ack_i && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || !req_i || ack_i || timeout_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute sequencer owning PC, IR and the shared memory port.
// Latency: jump 3, alu/store 4, load 5 cycles plus ack waits; stalls on mem_ack, halts on timeout.
module cpu_control_fsm
    import ctrl_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 16,
    parameter int RET_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       ir,
    input  logic [4:0]        address,
    input  logic              is_arithmetic,
    input  logic              is_immediate,
    input  logic              is_load,
    input  logic              is_store,
    input  logic              is_jump_unconditional,
    input  logic              is_jump_conditional,
    input  logic              zero_flag,
    output logic              alu_en,
    output logic              alu_imm,
    output logic              rf_we,
    output logic              wb_sel,
    output logic [15:0]       ld_data,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              bus_error,
    output logic [RET_W-1:0]  retired
);

    state_t            state_q, state_d;
    logic              run_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [15:0]       ld_q, ld_d;
    logic [RET_W-1:0]  ret_q, ret_d;
    logic              berr_q, berr_d;
    logic              retire;
    logic              timeout;
    logic              any_class;
    logic [ADDR_W-1:0] field_addr;

    assign field_addr = ADDR_W'(address);
    assign any_class  = is_arithmetic | is_immediate | is_load | is_store
                      | is_jump_unconditional | is_jump_conditional;

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (mem_req),
        .ack_i     (mem_ack),
        .clr_i     (state_d != state_q),
        .timeout_o (timeout)
    );

    // run_q keeps every strobe low until the first edge after reset release.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ld_d     = ld_q;
        berr_d   = berr_q;
        retire   = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        alu_en   = 1'b0;
        alu_imm  = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = WB_ALU;
        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc_q;
                    if (mem_ack) begin
                        ir_d    = mem_rdata;
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = S_DECODE;
                    end else if (timeout) begin
                        berr_d  = 1'b1;
                        state_d = S_HALT;
                    end
                end
                S_DECODE: begin
                    state_d = any_class ? S_EXEC : S_HALT;
                end
                S_EXEC: begin
                    if (is_arithmetic) begin
                        alu_en  = 1'b1;
                        state_d = S_WB;
                    end else if (is_immediate) begin
                        alu_en  = 1'b1;
                        alu_imm = 1'b1;
                        state_d = S_WB;
                    end else if (is_load || is_store) begin
                        state_d = S_MEM;
                    end else if (is_jump_unconditional) begin
                        pc_d    = field_addr;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else if (is_jump_conditional) begin
                        if (zero_flag) begin
                            pc_d = field_addr;
                        end
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_HALT;
                    end
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    mem_addr = field_addr;
                    mem_we   = is_store;
                    if (mem_ack) begin
                        if (is_store) begin
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            ld_d    = mem_rdata;
                            state_d = S_WB;
                        end
                    end else if (timeout) begin
                        berr_d  = 1'b1;
                        state_d = S_HALT;
                    end
                end
                S_WB: begin
                    rf_we   = 1'b1;
                    wb_sel  = is_load ? WB_MEM : WB_ALU;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_HALT;
                end
            endcase
        end
        ret_d = retire ? ret_q + RET_W'(1) : ret_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
            pc_q    <= '0;
            ir_q    <= '0;
            ld_q    <= '0;
            ret_q   <= '0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ld_q    <= ld_d;
            ret_q   <= ret_d;
            berr_q  <= berr_d;
        end
    end

    assign ir        = ir_q;
    assign pc        = pc_q;
    assign ld_data   = ld_q;
    assign retired   = ret_q;
    assign bus_error = berr_q;
    assign halted    = (state_q == S_HALT);

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
- Multi-cycle sequencer for the 16-bit CISC core.
- Owns the PC and the instruction register, and arbitrates the single memory port between instruction fetch and load/store.
- Drives the instruction decoder (ir out, class flags back) and the register file and ALU enables.
- Halts on an illegal class or a memory timeout.

Parameters:
- ADDR_W, 5, PC and memory address width; the 5-bit address field is zero-extended or truncated to this width.
- TIMEOUT, 16, maximum cycles mem_req stays high without mem_ack before bus error; must be ≥1.
- RET_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = store, 0 = read.
- mem_addr  out  ADDR_W  access address.
- mem_ack  in  1  access complete; read data valid in the same cycle.
- mem_rdata  in  16  read data.
- ir  out  16  instruction register, to the decoder.
- address  in  5  decoder address field.
- is_arithmetic, is_immediate, is_load, is_store, is_jump_unconditional, is_jump_conditional  in  1 each  decoder class flags.
- zero_flag  in  1  ALU zero result.
- alu_en  out  1  ALU evaluate.
- alu_imm  out  1  ALU operand B = immediate.
- rf_we  out  1  register-file write.
- wb_sel  out  1  0 = ALU result, 1 = load data.
- ld_data  out  16  captured load data.
- pc  out  ADDR_W  program counter.
- halted  out  1  sticky halt.
- bus_error  out  1  sticky; halt was caused by timeout.
- retired  out  RET_W  instructions retired, wraps.

Behaviour:
- Reset (asynchronous, any state, mid-access included): state=FETCH; pc, ir, ld_data, retired, halted, bus_error = 0. All strobes (mem_req, mem_we, alu_en, alu_imm, rf_we, wb_sel) = 0 until the first clk edge after deassert.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On an edge with mem_ack=1: ir<=mem_rdata, pc<=pc+1 (mod 2^ADDR_W), go to DECODE.
  - mem_ack in the request cycle is legal, so a fetch takes at least 1 cycle.
- DECODE: one cycle; the decoder settles on the new ir. Class from flags; no flag set (ir[15:13]=110/111) -> HALT.
- EXEC, by class:
  - Arithmetic: alu_en=1 -> WB.
  - Immediate: alu_en=1, alu_imm=1 -> WB.
  - Load or store -> MEM.
  - Unconditional jump: pc<=address, retire -> FETCH.
  - Conditional jump: if zero_flag (sampled this cycle) then pc<=address; retire -> FETCH.
- MEM:
  - mem_req=1, mem_addr=address, mem_we=is_store.
  - On ack: a load captures ld_data<=mem_rdata -> WB; a store retires -> FETCH.
- WB: rf_we=1 for exactly one cycle; wb_sel=is_load; retire -> FETCH.
- Retire means retired<=retired+1, wrapping.
- Minimum latency with zero-wait ack:
  - jump 3 cycles;
  - arithmetic, immediate and store 4;
  - load 5.
- Handshake:
  - mem_addr and mem_we stay stable while mem_req=1.
  - mem_req never drops before ack, except on timeout or reset.
  - mem_ack is ignored when mem_req=0.
- Watchdog:
  - Counts consecutive cycles with mem_req=1 and mem_ack=0.
  - Reaching TIMEOUT -> HALT with bus_error=1.
  - Ack on the same edge the count reaches TIMEOUT: the ack wins.
  - Counter clears on ack and on state change.
- HALT:
  - halted=1; all strobes 0; pc and ir hold.
  - Exit only via reset.
- Simultaneous events: a jump target equal to pc+1 is legal. pc wraps from 2^ADDR_W-1 to 0 without error.

Decomposition:
- Shared package ctrl_pkg:
  - state enum;
  - class codes 000 load, 001 store, 010 arithmetic, 011 immediate, 100 jump, 101 conditional jump;
  - WB_ALU=0 and WB_MEM=1 constants.
- One sub-module, mem_watchdog: count/clear/timeout output, parameterised by TIMEOUT.

Test Plan:
- Reset then ir=0x4A10 (arithmetic), zero-wait ack -> FETCH, DECODE, EXEC(alu_en), WB(rf_we, wb_sel=0); retired=1; pc=1.
- Load 0x0205 with ack delayed 3 cycles in MEM -> mem_addr=5 and mem_we=0 held 4 cycles; ld_data=mem_rdata; WB with wb_sel=1; 5 + 3 cycles total.
- Conditional jump 0xA00C:
  - with zero_flag=1 -> pc=12;
  - repeat with zero_flag=0 -> pc = old pc+1.
  - Both 3 cycles, no rf_we.
- Store 0x2107 -> mem_we=1, mem_addr=7, no rf_we; pc=31 wraps to 0 after the next fetch.
- Never assert mem_ack with TIMEOUT=4 -> after 4 request cycles: halted=1, bus_error=1, mem_req=0; stays halted.
- Illegal 0xC000 -> HALT, bus_error=0. Assert rst_n low mid-MEM on a later run -> mem_req falls asynchronously, state FETCH, pc=0.
